noc_request_axilite: RTL and testbench
======================================

Name: noc_request_axilite

Overview:
- Upstream neighbour of the NoC response/AXI-lite stage. Accepts AXI-lite read and write requests from the Ara memory port and serialises each into one NoC request packet: 3 header flits, plus data flits for stores.
- Pushes one transaction-type entry per accepted request into the response stage's type FIFO, so that responses can be steered to the B or R channel.
- Sits between the AXI-lite master and the NoC1 injection port.

Parameters:
- AXI_LITE_ADDR_WIDTH, 64, request address width (bits [39:0] used in header 1).
- AXI_LITE_DATA_WIDTH, 512, write data width; must be an integer multiple of `NOC_DATA_WIDTH (64).
- AXI_LITE_RESP_WIDTH, 2, kept for interface symmetry with the response stage.
- SRC_CHIPID, 14'd0, source chip id placed in header 2.
- SRC_X, 8'd0, source tile X coordinate placed in header 2.
- SRC_Y, 8'd0, source tile Y coordinate placed in header 2.
- DST_FBITS, 4'b0010, final-destination bits placed in header 0 (memory port).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- m_axi_awaddr  in  AXI_LITE_ADDR_WIDTH  write address.
- m_axi_awvalid  in  1  write address valid.
- m_axi_awready  out  1  write address accepted.
- m_axi_wdata  in  AXI_LITE_DATA_WIDTH  write data.
- m_axi_wstrb  in  AXI_LITE_DATA_WIDTH/8  write strobes.
- m_axi_wvalid  in  1  write data valid.
- m_axi_wready  out  1  write data accepted.
- m_axi_araddr  in  AXI_LITE_ADDR_WIDTH  read address.
- m_axi_arvalid  in  1  read address valid.
- m_axi_arready  out  1  read address accepted.
- noc_valid_out  out  1  flit valid.
- noc_data_out  out  `NOC_DATA_WIDTH  flit.
- noc_ready_in  in  1  NoC accepts flit.
- transaction_type_wr_data  out  3  {msg type[1:0], addr[3]}.
- transaction_type_wr  out  1  type FIFO push, one cycle.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; round-robin pointer = read-first; capture registers cleared.
- State machine states: IDLE, HDR0, HDR1, HDR2, DATA.
- IDLE, write candidate: a write is eligible only when awvalid && wvalid are both high.
- IDLE, read candidate: a read is eligible when arvalid is high.
- IDLE, arbitration: if both are eligible, the round-robin pointer selects, and the pointer flips after every grant. Otherwise the single eligible request is granted.
- Grant cycle outputs:
  - Write grant: awready = wready = 1 for exactly that cycle.
  - Read grant: arready = 1 for exactly that cycle.
  - Both: transaction_type_wr = 1 for that cycle.
  - The granted address, data and strobes are captured, and the state moves to HDR0.
- Ready signals are never asserted outside IDLE. They are combinational on the valids, so no AXI ready depends on noc_ready_in.
- Type encoding on transaction_type_wr_data:
  - Read: {2'd1 (LOAD), araddr[3]}.
  - Write: {2'd2 (STORE), 1'b0}.
- Header 0 fields:
  - `MSG_TYPE = `MSG_TYPE_NC_LOAD_REQ for a read, `MSG_TYPE_NC_STORE_REQ for a write.
  - `MSG_LENGTH = 2 for a read, 2 + AXI_LITE_DATA_WIDTH/64 for a write (10 at the default width).
  - Destination chip/X/Y = 0; fbits = DST_FBITS; MSHR id = 0.
- Header 1 fields: `MSG_ADDR = captured addr[39:0]; `MSG_DATA_SIZE = full-line encoding for AXI_LITE_DATA_WIDTH.
- Header 2 fields: SRC_CHIPID, SRC_X, SRC_Y, src fbits = 0.
- Flit transmission:
  - Each flit is held on noc_data_out with noc_valid_out = 1 until noc_ready_in.
  - The state/counter advances only on noc_valid_out && noc_ready_in.
  - Flit data must not change while stalled.
- DATA state: flit k (k = 0 upward) = byte-reversed wdata[k*64 +: 64], the inverse of the response stage's endian swap. A flit counter of width $clog2(AXI_LITE_DATA_WIDTH/64)+1 counts the data flits.
- End of packet:
  - Read: after the HDR2 handshake, return to IDLE.
  - Write: after the handshake of the last data flit, return to IDLE.
  - There is no back-to-back bypass: at least one IDLE cycle between packets.
- Throughput:
  - Minimum first-flit latency is 1 cycle after the grant.
  - Packet size: read = 3 flits, write = 3 + N flits (N = AXI_LITE_DATA_WIDTH/64).
- Strobes: wstrb is captured but not encoded. A partial strobe is forwarded as a full-line store; this is documented as a known limitation and flagged by an assertion in simulation.
- Back-to-back arrival: awvalid without wvalid (or the reverse) does not grant. A waiting write never blocks a read.
- Reset mid-packet: the packet is abandoned and noc_valid_out drops asynchronously. The type FIFO push has already occurred, so the system is reset as a whole.

Decomposition:
- Shared package noc_axilite_pkg holds:
  - the msg-type enum {INVAL = 0, LOAD = 1, STORE = 2}, also used by the response stage;
  - the request state enum;
  - the header field helper constants (flit counts, the data-size encoding function).
- One sub-module, noc_header_builder: combinational, producing the 3 header flits from type, address and length.

Test Plan:
- Single read: araddr = 0x8000_1048 -> arready for 1 cycle; type push data 3'b011; 3 flits with len = 2, addr = 0x80001048, NC_LOAD_REQ.
- Single write: awaddr = 0x8000_2000, wdata = incrementing bytes 0x00..0x3F -> 11 flits, len = 10. Data flit 0 = 0x0001020304050607 (byte-reversed), type push 3'b100.
- Simultaneous: aw, w and ar all valid from reset -> read granted first, then the write. Two type pushes in order LOAD, STORE.
- Backpressure: noc_ready_in low for 5 cycles on HDR1 and on data flit 3 -> flits stable, no flit lost or duplicated, no AXI ready asserted during the stall.
- awvalid = 1, wvalid = 0 for 10 cycles while ar is pulsed -> read completes; write granted only in the cycle after wvalid rises.
- rst_n asserted mid-DATA of a write -> all outputs 0 immediately. After release, a new read produces a clean 3-flit packet.

Source files
------------

// File: rtl/noc_axilite_pkg.sv
// Shared types and NoC header helpers for the AXI-lite <-> NoC request/response stages.
// Holds the message-type enum, the request FSM states and the field encodings.
package noc_axilite_pkg;

  localparam int NOC_DATA_WIDTH = 64;
  localparam int HDR_FLITS      = 3;

  localparam logic [7:0] MSG_TYPE_NC_LOAD_REQ  = 8'd14;
  localparam logic [7:0] MSG_TYPE_NC_STORE_REQ = 8'd15;

  typedef enum logic [1:0] {
    INVAL = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } msg_type_e;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    HDR2,
    DATA
  } req_state_e;

  function automatic int data_flits(input int width_bits);
    return width_bits / NOC_DATA_WIDTH;
  endfunction

  // Data-size field: 1 byte -> 1, doubling per step, so a 64-byte line -> 7.
  function automatic logic [2:0] data_size_enc(input int width_bits);
    int enc;
    int bytes;
    enc   = 1;
    bytes = width_bits / 8;
    for (int b = 1; b < bytes; b = b * 2) enc++;
    return 3'(enc);
  endfunction

  function automatic logic [63:0] byte_swap64(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int b = 0; b < 8; b++) y[8*b +: 8] = x[8*(7-b) +: 8];
    return y;
  endfunction

endpackage

// File: rtl/noc_request_axilite_if.sv
// AXI-lite request-side channels (AW, W, AR) from the Ara memory port.
// The master drives addresses, data and valids; the slave returns the readies.
interface noc_request_axilite_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 512
);
  logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
  logic                    m_axi_awvalid;
  logic                    m_axi_awready;
  logic [DATA_WIDTH-1:0]   m_axi_wdata;
  logic [DATA_WIDTH/8-1:0] m_axi_wstrb;
  logic                    m_axi_wvalid;
  logic                    m_axi_wready;
  logic [ADDR_WIDTH-1:0]   m_axi_araddr;
  logic                    m_axi_arvalid;
  logic                    m_axi_arready;

  modport master (
    output m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
           m_axi_araddr, m_axi_arvalid,
    input  m_axi_awready, m_axi_wready, m_axi_arready
  );

  modport slave (
    input  m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
           m_axi_araddr, m_axi_arvalid,
    output m_axi_awready, m_axi_wready, m_axi_arready
  );
endinterface

// File: rtl/noc_header_builder.sv
// Combinational builder of the three NoC request header flits
// from message type, 40-bit address and packet length.
module noc_header_builder
  import noc_axilite_pkg::*;
#(
  parameter logic [13:0] SRC_CHIPID = 14'd0,
  parameter logic [7:0]  SRC_X      = 8'd0,
  parameter logic [7:0]  SRC_Y      = 8'd0,
  parameter logic [3:0]  DST_FBITS  = 4'b0010,
  parameter logic [2:0]  DATA_SIZE  = 3'd7
) (
  input  msg_type_e   msg_type_i,
  input  logic [39:0] addr_i,
  input  logic [7:0]  len_i,
  output logic [63:0] hdr0_o,
  output logic [63:0] hdr1_o,
  output logic [63:0] hdr2_o
);

  // Layout: chip[63:50] x[49:42] y[41:34] fbits[33:30] len[29:22] type[21:14] mshr[13:6].
  always_comb begin
    // NOTE: default every output first so no path through the block can infer a latch.
    hdr0_o = '0;
    hdr1_o = '0;
    hdr2_o = '0;

    hdr0_o[33:30] = DST_FBITS;
    hdr0_o[29:22] = len_i;
    hdr0_o[21:14] = (msg_type_i == STORE) ? MSG_TYPE_NC_STORE_REQ : MSG_TYPE_NC_LOAD_REQ;

    hdr1_o[55:16] = addr_i;
    hdr1_o[15:13] = DATA_SIZE;

    hdr2_o[63:50] = SRC_CHIPID;
    hdr2_o[49:42] = SRC_X;
    hdr2_o[41:34] = SRC_Y;
  end

endmodule

// File: rtl/noc_request_axilite.sv
// Serialises AXI-lite reads/writes into NoC1 request packets (3 headers + data flits
// for stores) and pushes a transaction-type entry for the response stage per grant.
module noc_request_axilite
  import noc_axilite_pkg::*;
#(
  parameter int          AXI_LITE_ADDR_WIDTH = 64,
  parameter int          AXI_LITE_DATA_WIDTH = 512,
  parameter int          AXI_LITE_RESP_WIDTH = 2,
  parameter logic [13:0] SRC_CHIPID          = 14'd0,
  parameter logic [7:0]  SRC_X               = 8'd0,
  parameter logic [7:0]  SRC_Y               = 8'd0,
  parameter logic [3:0]  DST_FBITS           = 4'b0010
) (
  input  logic                      clk,
  input  logic                      rst_n,
  noc_request_axilite_if.slave      axi,
  output logic                      noc_valid_out,
  output logic [NOC_DATA_WIDTH-1:0] noc_data_out,
  input  logic                      noc_ready_in,
  output logic [2:0]                transaction_type_wr_data,
  output logic                      transaction_type_wr
);

  localparam int          N_DATA = data_flits(AXI_LITE_DATA_WIDTH);
  localparam int          CNT_W  = $clog2(N_DATA) + 1;
  localparam logic [7:0]  LEN_RD = 8'(HDR_FLITS - 1);
  localparam logic [7:0]  LEN_WR = 8'(HDR_FLITS - 1 + N_DATA);
  localparam logic [2:0]  DSIZE  = data_size_enc(AXI_LITE_DATA_WIDTH);

  if (AXI_LITE_DATA_WIDTH % NOC_DATA_WIDTH != 0 || AXI_LITE_RESP_WIDTH < 1 ||
      AXI_LITE_ADDR_WIDTH < 40) begin : g_bad_cfg
    $error("noc_request_axilite: unsupported width configuration");
  end

  req_state_e                     state_q;
  logic                           rr_q;      // 0 = read wins a tie, 1 = write wins
  logic                           is_wr_q;
  logic [39:0]                    addr_q;
  logic [AXI_LITE_DATA_WIDTH-1:0] wdata_q;
  logic [AXI_LITE_DATA_WIDTH/8-1:0] wstrb_q;
  logic [CNT_W-1:0]               cnt_q;
  logic                           valid_q;
  logic [NOC_DATA_WIDTH-1:0]      flit_q;

  logic        in_idle, rd_elig, wr_elig, grant_rd, grant_wr, hs;
  logic        b_is_wr;
  msg_type_e   b_type;
  logic [39:0] b_addr;
  logic [7:0]  b_len;
  logic [63:0] hdr0, hdr1, hdr2;

  // Grants are combinational on the valids and never look at noc_ready_in.
  assign in_idle  = (state_q == IDLE) && rst_n;
  assign rd_elig  = axi.m_axi_arvalid;
  assign wr_elig  = axi.m_axi_awvalid && axi.m_axi_wvalid;
  assign grant_rd = in_idle && rd_elig && (!wr_elig || !rr_q);
  assign grant_wr = in_idle && wr_elig && (!rd_elig || rr_q);
  assign hs       = valid_q && noc_ready_in;

  assign axi.m_axi_arready = grant_rd;
  assign axi.m_axi_awready = grant_wr;
  assign axi.m_axi_wready  = grant_wr;

  assign transaction_type_wr      = grant_rd || grant_wr;
  assign transaction_type_wr_data = grant_rd ? {LOAD, axi.m_axi_araddr[3]} :
                                    grant_wr ? {STORE, 1'b0} : 3'b000;

  // In IDLE the header source is the request being granted; afterwards the captured one.
  assign b_is_wr = (state_q == IDLE) ? grant_wr : is_wr_q;
  assign b_type  = b_is_wr ? STORE : LOAD;
  assign b_len   = b_is_wr ? LEN_WR : LEN_RD;
  assign b_addr  = (state_q != IDLE) ? addr_q :
                   grant_wr ? axi.m_axi_awaddr[39:0] : axi.m_axi_araddr[39:0];

  noc_header_builder #(
    .SRC_CHIPID (SRC_CHIPID),
    .SRC_X      (SRC_X),
    .SRC_Y      (SRC_Y),
    .DST_FBITS  (DST_FBITS),
    .DATA_SIZE  (DSIZE)
  ) u_hdr (
    .msg_type_i (b_type),
    .addr_i     (b_addr),
    .len_i      (b_len),
    .hdr0_o     (hdr0),
    .hdr1_o     (hdr1),
    .hdr2_o     (hdr2)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      flit_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_rd || grant_wr) begin
            state_q <= HDR0;
            rr_q    <= ~rr_q;
            is_wr_q <= grant_wr;
            addr_q  <= b_addr;
            if (grant_wr) begin
              wdata_q <= axi.m_axi_wdata;
              wstrb_q <= axi.m_axi_wstrb;
            end
            valid_q <= 1'b1;
            flit_q  <= hdr0;
          end
        end
        HDR0: if (hs) begin
          state_q <= HDR1;
          flit_q  <= hdr1;
        end
        HDR1: if (hs) begin
          state_q <= HDR2;
          flit_q  <= hdr2;
        end
        HDR2: if (hs) begin
          if (is_wr_q) begin
            state_q <= DATA;
            cnt_q   <= '0;
            flit_q  <= byte_swap64(wdata_q[0 +: NOC_DATA_WIDTH]);
          end else begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            flit_q  <= '0;
          end
        end
        DATA: if (hs) begin
          if (cnt_q == CNT_W'(N_DATA - 1)) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            flit_q  <= '0;
          end else begin
            cnt_q  <= cnt_q + 1'b1;
            flit_q <= byte_swap64(wdata_q[NOC_DATA_WIDTH*(int'(cnt_q) + 1) +: NOC_DATA_WIDTH]);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign noc_valid_out = valid_q;
  assign noc_data_out  = flit_q;

  // Strobes are not encoded in the packet; a partial strobe still goes out as a full line.
  a_full_strobe: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == HDR0 && is_wr_q) |-> (&wstrb_q))
    else $warning("partial write strobe forwarded as a full-line store");

endmodule

// File: tb/tb_noc_request_axilite.sv
// Randomised and directed bench for noc_request_axilite against a packet-level
// reference model (expected flit queue + round-robin arbiter model).
module tb_noc_request_axilite;
  localparam int          AW = 64;
  localparam int          DW = 512;
  localparam int          NF = DW / 64;
  localparam logic [13:0] SRC_CHIPID = 14'h123;
  localparam logic [7:0]  SRC_X      = 8'h45;
  localparam logic [7:0]  SRC_Y      = 8'h67;
  localparam logic [3:0]  DST_FBITS  = 4'b0010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        noc_valid_out;
  logic [63:0] noc_data_out;
  logic        noc_ready_in;
  logic [2:0]  transaction_type_wr_data;
  logic        transaction_type_wr;

  noc_request_axilite_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi_if ();

  noc_request_axilite #(
    .AXI_LITE_ADDR_WIDTH (AW),
    .AXI_LITE_DATA_WIDTH (DW),
    .AXI_LITE_RESP_WIDTH (2),
    .SRC_CHIPID          (SRC_CHIPID),
    .SRC_X               (SRC_X),
    .SRC_Y               (SRC_Y),
    .DST_FBITS           (DST_FBITS)
  ) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .axi                      (axi_if),
    .noc_valid_out            (noc_valid_out),
    .noc_data_out             (noc_data_out),
    .noc_ready_in             (noc_ready_in),
    .transaction_type_wr_data (transaction_type_wr_data),
    .transaction_type_wr      (transaction_type_wr)
  );

  always #5 clk = ~clk;

  int          n_vectors     = 0;
  int          n_miscompares = 0;
  logic [63:0] exp_flits[$];
  logic [63:0] seen_flits[$];
  logic [2:0]  seen_types[$];
  bit          model_rr;      // 1 once a read has been granted and a tie would go to the write
  int          flits_seen;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] swap_bytes(input logic [63:0] x);
    return {<<8{x}};
  endfunction

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [DW-1:0] ramp_line();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/8; i++) v[i*8 +: 8] = 8'(i);
    return v;
  endfunction

  // Expected packet built straight from the field definitions.
  task automatic push_packet(input bit is_wr, input logic [63:0] addr, input logic [DW-1:0] wdata);
    logic [63:0] len, mt, h0, h1, h2;
    len = is_wr ? 64'(2 + NF) : 64'd2;
    mt  = is_wr ? 64'd15 : 64'd14;
    h0  = (len << 22) | (mt << 14) | (64'(DST_FBITS) << 30);
    h1  = (64'(addr[39:0]) << 16) | (64'd7 << 13);
    h2  = (64'(SRC_CHIPID) << 50) | (64'(SRC_X) << 42) | (64'(SRC_Y) << 34);
    exp_flits.push_back(h0);
    exp_flits.push_back(h1);
    exp_flits.push_back(h2);
    if (is_wr)
      for (int k = 0; k < NF; k++) exp_flits.push_back(swap_bytes(wdata[k*64 +: 64]));
  endtask

  // Reference model evaluated each cycle, sampled mid-cycle.
  always @(negedge clk) begin : monitor
    bit idle, er, ew, wr_ok;
    if (rst_n) begin
      idle = (exp_flits.size() == 0);
      check("noc_valid", noc_valid_out, !idle);
      if (noc_valid_out && !idle) begin
        check("flit", noc_data_out, exp_flits[0]);
        if (noc_ready_in) begin
          void'(exp_flits.pop_front());
          seen_flits.push_back(noc_data_out);
          flits_seen++;
        end
      end
      wr_ok = axi_if.m_axi_awvalid && axi_if.m_axi_wvalid;
      er = idle && axi_if.m_axi_arvalid && (!wr_ok || !model_rr);
      ew = idle && wr_ok && (!axi_if.m_axi_arvalid || model_rr);
      check("arready", axi_if.m_axi_arready, er);
      check("awready", axi_if.m_axi_awready, ew);
      check("wready", axi_if.m_axi_wready, ew);
      check("type_wr", transaction_type_wr, er || ew);
      if (er || ew) begin
        check("type_data", transaction_type_wr_data,
              er ? {2'd1, axi_if.m_axi_araddr[3]} : 3'b100);
        seen_types.push_back(transaction_type_wr_data);
        if (er) push_packet(1'b0, axi_if.m_axi_araddr, '0);
        else    push_packet(1'b1, axi_if.m_axi_awaddr, axi_if.m_axi_wdata);
        model_rr = !model_rr;
      end
    end
  end

  // One clock of AXI-master behaviour: drop each valid after its handshake.
  task automatic step();
    bit ar_hs, aw_hs, w_hs;
    @(negedge clk);
    ar_hs = axi_if.m_axi_arvalid && axi_if.m_axi_arready;
    aw_hs = axi_if.m_axi_awvalid && axi_if.m_axi_awready;
    w_hs  = axi_if.m_axi_wvalid  && axi_if.m_axi_wready;
    @(posedge clk);
    #1;
    if (ar_hs) axi_if.m_axi_arvalid = 1'b0;
    if (aw_hs) axi_if.m_axi_awvalid = 1'b0;
    if (w_hs)  axi_if.m_axi_wvalid  = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      done = (exp_flits.size() == 0) && !noc_valid_out && !axi_if.m_axi_arvalid &&
             !axi_if.m_axi_awvalid && !axi_if.m_axi_wvalid;
    end
    check({tag, "_drained"}, done, 1'b1);
  endtask

  task automatic wait_flits(input string tag, input int n, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      done = (flits_seen >= n);
    end
    check({tag, "_reached"}, done, 1'b1);
  endtask

  task automatic clear_logs();
    seen_flits.delete();
    seen_types.delete();
    flits_seen = 0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin : stimulus
    rst_n                = 1'b0;
    noc_ready_in         = 1'b1;
    model_rr             = 1'b0;
    flits_seen           = 0;
    axi_if.m_axi_wstrb   = '1;
    // All three requests pending out of reset.
    axi_if.m_axi_araddr  = 64'h0000_0000_1000_0008;
    axi_if.m_axi_arvalid = 1'b1;
    axi_if.m_axi_awaddr  = 64'h0000_0000_8000_2000;
    axi_if.m_axi_wdata   = ramp_line();
    axi_if.m_axi_awvalid = 1'b1;
    axi_if.m_axi_wvalid  = 1'b1;
    #1;
    check("rst_valid", noc_valid_out, 1'b0);
    check("rst_data", noc_data_out, 64'd0);
    check("rst_arready", axi_if.m_axi_arready, 1'b0);
    check("rst_awready", axi_if.m_axi_awready, 1'b0);
    check("rst_type_wr", transaction_type_wr, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Simultaneous: read first, then write.
    wait_idle("simul", 200);
    check("simul_npush", seen_types.size(), 2);
    if (seen_types.size() == 2) begin
      check("simul_first", seen_types[0], 3'b011);
      check("simul_second", seen_types[1], 3'b100);
    end
    check("simul_nflits", seen_flits.size(), 3 + 3 + NF);

    // Single read.
    clear_logs();
    axi_if.m_axi_araddr  = 64'h0000_0000_8000_1048;
    axi_if.m_axi_arvalid = 1'b1;
    wait_idle("rd", 100);
    check("rd_nflits", seen_flits.size(), 3);
    if (seen_flits.size() == 3) begin
      check("rd_len", seen_flits[0][29:22], 8'd2);
      check("rd_msgtype", seen_flits[0][21:14], 8'd14);
      check("rd_hdr1", seen_flits[1], 64'h0000_8000_1048_E000);
    end
    if (seen_types.size() == 1) check("rd_type", seen_types[0], 3'b011);

    // Single write with ramp data.
    clear_logs();
    axi_if.m_axi_awaddr  = 64'h0000_0000_8000_2000;
    axi_if.m_axi_wdata   = ramp_line();
    axi_if.m_axi_awvalid = 1'b1;
    axi_if.m_axi_wvalid  = 1'b1;
    wait_idle("wr", 100);
    check("wr_nflits", seen_flits.size(), 3 + NF);
    if (seen_flits.size() == 3 + NF) begin
      check("wr_len", seen_flits[0][29:22], 8'd10);
      check("wr_dflit0", seen_flits[3], 64'h0001_0203_0405_0607);
    end
    if (seen_types.size() == 1) check("wr_type", seen_types[0], 3'b100);

    // Backpressure on HDR1 and data flit 3, with a read waiting throughout.
    clear_logs();
    axi_if.m_axi_awaddr  = {$urandom, $urandom};
    axi_if.m_axi_wdata   = rand_line();
    axi_if.m_axi_awvalid = 1'b1;
    axi_if.m_axi_wvalid  = 1'b1;
    wait_flits("bp_hdr1", 1, 50);
    noc_ready_in = 1'b0;
    axi_if.m_axi_araddr  = {$urandom, $urandom};
    axi_if.m_axi_arvalid = 1'b1;
    repeat (5) step();
    noc_ready_in = 1'b1;
    wait_flits("bp_d3", 6, 50);
    noc_ready_in = 1'b0;
    repeat (5) step();
    noc_ready_in = 1'b1;
    wait_idle("bp", 200);
    check("bp_nflits", seen_flits.size(), 3 + NF + 3);

    // Write address without data must not grant; a read passes it.
    clear_logs();
    axi_if.m_axi_awaddr  = {$urandom, $urandom};
    axi_if.m_axi_wdata   = rand_line();
    axi_if.m_axi_awvalid = 1'b1;
    axi_if.m_axi_araddr  = {$urandom, $urandom};
    axi_if.m_axi_arvalid = 1'b1;
    repeat (10) step();
    check("aw_alone_held", axi_if.m_axi_awvalid, 1'b1);
    check("aw_alone_rd_done", seen_flits.size(), 3);
    axi_if.m_axi_wvalid = 1'b1;
    #1;
    check("aw_grant_after_w", axi_if.m_axi_awready, 1'b1);
    check("w_grant_after_w", axi_if.m_axi_wready, 1'b1);
    wait_idle("aw_alone", 100);

    // Randomised traffic with random backpressure.
    for (int c = 0; c < 1500; c++) begin
      step();
      if (!axi_if.m_axi_arvalid && $urandom_range(0, 3) == 0) begin
        axi_if.m_axi_araddr  = {$urandom, $urandom};
        axi_if.m_axi_arvalid = 1'b1;
      end
      if (!axi_if.m_axi_awvalid && $urandom_range(0, 4) == 0) begin
        axi_if.m_axi_awaddr  = {$urandom, $urandom};
        axi_if.m_axi_awvalid = 1'b1;
      end
      if (!axi_if.m_axi_wvalid && $urandom_range(0, 4) == 0) begin
        axi_if.m_axi_wdata  = rand_line();
        axi_if.m_axi_wvalid = 1'b1;
      end
      noc_ready_in = ($urandom_range(0, 3) != 0);
    end
    noc_ready_in = 1'b1;
    wait_idle("rand", 400);

    // Reset in the middle of a write's data phase.
    clear_logs();
    axi_if.m_axi_awaddr  = {$urandom, $urandom};
    axi_if.m_axi_wdata   = rand_line();
    axi_if.m_axi_awvalid = 1'b1;
    axi_if.m_axi_wvalid  = 1'b1;
    wait_flits("mid_rst", 5, 50);
    #2;
    rst_n = 1'b0;
    axi_if.m_axi_awvalid = 1'b0;
    axi_if.m_axi_wvalid  = 1'b0;
    axi_if.m_axi_arvalid = 1'b0;
    exp_flits.delete();
    model_rr = 1'b0;
    #1;
    check("mid_rst_valid", noc_valid_out, 1'b0);
    check("mid_rst_data", noc_data_out, 64'd0);
    check("mid_rst_type_wr", transaction_type_wr, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_logs();
    axi_if.m_axi_araddr  = {$urandom, $urandom};
    axi_if.m_axi_arvalid = 1'b1;
    wait_idle("post_rst", 100);
    check("post_rst_nflits", seen_flits.size(), 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
